mod3_round_stream: RTL and testbench

//  Streaming centered-lift + mod-M reducer for decapsulation: takes P coefficients in [0,q),

---
 rtl/sntrup_pkg.sv | 23 ++
 rtl/mod_shiftsub_core.sv | 57 +++++
 rtl/mod3_round_stream.sv | 176 +++++++++++++++++
 tb/tb_mod3_round_stream.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sntrup_pkg.sv
// Shared constants, trit encodings and controller states for the Rq->R3 rounding stream.
package sntrup_pkg;

    localparam int Q_DEF = 4591;
    localparam int P_DEF = 761;
    localparam int W_DEF = 13;

    // Two's-complement trit encodings for the M=3 build.
    localparam logic [1:0] TRIT_P1 = 2'b01;
    localparam logic [1:0] TRIT_0  = 2'b00;
    localparam logic [1:0] TRIT_M1 = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_CENTER  = 3'd3,
        ST_REDUCE  = 3'd4,
        ST_EMIT    = 3'd5,
        ST_DONE    = 3'd6
    } state_e;

endpackage

// File: rtl/mod_shiftsub_core.sv
// Iterative shift-subtract reducer: a is loaded once, then each step removes
// M<<k for k = ITER-1 down to 0, leaving a mod M after the final step.
module mod_shiftsub_core #(
    parameter int W    = 13,
    parameter int M    = 3,
    parameter int ITER = W - 1,
    parameter int RW   = $clog2(M)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic [W-1:0]  a_i,
    input  logic          step_i,
    output logic          last_o,
    output logic [RW-1:0] r_o
);

    localparam int AW = W + 2;
    localparam int KW = (ITER > 1) ? $clog2(ITER) : 1;

    logic [AW-1:0] a_q, a_d, sub;
    logic [KW-1:0] k_q, k_d;

    // Next-state: load resets the shift index, each step tries one shifted subtract.
    always_comb begin
        a_d = a_q;
        k_d = k_q;
        sub = AW'(M) << k_q;
        if (load_i) begin
            a_d = AW'(a_i);
            k_d = KW'(ITER - 1);
        end else if (step_i) begin
            if (a_q >= sub) begin
                a_d = a_q - sub;
            end
            if (k_q != '0) begin
                k_d = k_q - 1'b1;
            end
        end
    end

    // Magnitude and shift-index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            k_q <= '0;
        end else begin
            a_q <= a_d;
            k_q <= k_d;
        end
    end

    // High while the step about to happen is the k=0 one.
    assign last_o = (k_q == '0);
    assign r_o    = a_q[RW-1:0];

endmodule

// File: rtl/mod3_round_stream.sv
// Streaming centered lift of [0,q) coefficients followed by a centered mod-M reduction.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  ST_IDLE    | waiting for start; q and n_coeffs sampled on start
//  ST_CHECK   | reject even q / q<M (err) or an empty run
//  ST_CAPTURE | in_ready high, register one coefficient on handshake
//  ST_CENTER  | lift to centered value, load |c| into the reducer, keep sign
//  ST_REDUCE  | ITER shift-subtract steps
//  ST_EMIT    | out_valid high, hold residue until out_ready
//  ST_DONE    | one-cycle done pulse, busy still high
module mod3_round_stream
    import sntrup_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int M     = 3,
    parameter int OUT_W = 2,
    parameter int CNT_W = 10,
    parameter int ITER  = W - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     q,
    input  logic [CNT_W-1:0] n_coeffs,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_coef,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_coef,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int RW   = $clog2(M);
    localparam int HALF = (M - 1) / 2;

    state_e           state_q, state_d;
    logic [W-1:0]     x_q, x_d, q_q, q_d;
    logic [CNT_W-1:0] n_q, n_d, cnt_q, cnt_d;
    logic             s_q, s_d, err_q, err_d;

    logic [W-1:0]     x_eff, a_mag;
    logic             neg;
    logic             core_load, core_step, core_last;
    logic [RW-1:0]    core_r;
    logic [OUT_W-1:0] r_ext, r_lift, out_val;

    // Centered lift; an out-of-range coefficient is treated as zero.
    always_comb begin
        x_eff = (x_q >= q_q) ? '0 : x_q;
        neg   = x_eff > ((q_q - W'(1)) >> 1);
        a_mag = neg ? (q_q - x_eff) : x_eff;
    end

    mod_shiftsub_core #(
        .W    (W),
        .M    (M),
        .ITER (ITER),
        .RW   (RW)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (core_load),
        .a_i    (a_mag),
        .step_i (core_step),
        .last_o (core_last),
        .r_o    (core_r)
    );

    // Map residue [0,M) to the centered range and apply the held sign, modulo 2^OUT_W.
    always_comb begin
        r_ext   = OUT_W'(core_r);
        r_lift  = (core_r > RW'(HALF)) ? (r_ext - OUT_W'(M)) : r_ext;
        out_val = s_q ? (OUT_W'(0) - r_lift) : r_lift;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        q_d       = q_q;
        n_d       = n_q;
        cnt_d     = cnt_q;
        s_d       = s_q;
        err_d     = err_q;
        core_load = 1'b0;
        core_step = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    q_d     = q;
                    n_d     = n_coeffs;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!q_q[0] || (q_q < W'(M))) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (n_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    x_d     = in_coef;
                    state_d = ST_CENTER;
                end
            end
            ST_CENTER: begin
                core_load = 1'b1;
                s_d       = neg;
                if (x_q >= q_q) begin
                    err_d = 1'b1;
                end
                state_d = ST_REDUCE;
            end
            ST_REDUCE: begin
                core_step = 1'b1;
                if (core_last) begin
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (cnt_d == n_q) ? ST_DONE : ST_CAPTURE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller state, run parameters and captured coefficient.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            q_q     <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            s_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            q_q     <= q_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            err_q   <= err_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign err      = err_q;
    assign out_coef = (state_q == ST_EMIT) ? out_val : '0;

endmodule

// File: tb/tb_mod3_round_stream.sv
// Directed bench for mod3_round_stream (M=3 default build plus an M=5 instance).
module tb_mod3_round_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [12:0] q;
    logic [9:0]  n_coeffs;
    logic        in_valid;
    logic [12:0] in_coef;
    logic        out_ready;
    logic        in_ready, out_valid, busy, done, err;
    logic [1:0]  out_coef;

    logic        f_start;
    logic [12:0] f_q;
    logic [9:0]  f_n;
    logic        f_in_valid;
    logic [12:0] f_in_coef;
    logic        f_out_ready;
    logic        f_in_ready, f_out_valid, f_busy, f_done, f_err;
    logic [3:0]  f_out_coef;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mod3_round_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .q         (q),
        .n_coeffs  (n_coeffs),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_coef   (in_coef),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_coef  (out_coef),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    mod3_round_stream #(.M(5), .OUT_W(4)) dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (f_start),
        .q         (f_q),
        .n_coeffs  (f_n),
        .in_valid  (f_in_valid),
        .in_ready  (f_in_ready),
        .in_coef   (f_in_coef),
        .out_valid (f_out_valid),
        .out_ready (f_out_ready),
        .out_coef  (f_out_coef),
        .busy      (f_busy),
        .done      (f_done),
        .err       (f_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_run(input logic [12:0] qv, input logic [9:0] nv);
        @(negedge clk);
        start = 1'b1; q = qv; n_coeffs = nv;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push(input logic [12:0] x, input string tag);
        int n;
        n = 0;
        in_valid = 1'b1; in_coef = x;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk); n++;
        end
        check_eq({tag, "_rdy_timeout"}, 32'(n >= 50), 0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input logic [1:0] exp, input string tag, output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 50) begin
            @(negedge clk); lat++;
        end
        check_eq({tag, "_val"}, 32'(out_coef), 32'(exp));
    endtask

    task automatic run_one(input logic [12:0] x, input logic [1:0] exp, input string tag);
        int lat;
        push(x, tag);
        wait_out(exp, tag, lat);
        check_eq({tag, "_lat"}, 32'(lat), 13);
    endtask

    task automatic end_run(input string tag);
        @(negedge clk);
        check_eq({tag, "_done_hi"}, 32'({done, busy}), 32'b11);
        @(negedge clk);
        check_eq({tag, "_done_lo"}, 32'({done, busy}), 32'b00);
    endtask

    initial begin
        int lat, n;
        logic saw_rdy, saw_done;

        rst_n = 1'b0; start = 1'b0; q = '0; n_coeffs = '0;
        in_valid = 1'b0; in_coef = '0; out_ready = 1'b1;
        f_start = 1'b0; f_q = '0; f_n = '0; f_in_valid = 1'b0; f_in_coef = '0; f_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("reset_outs", 32'({in_ready, out_valid, busy, done, err, out_coef}), 0);
        rst_n = 1'b1;

        // 1: basic vectors
        start_run(13'd4591, 10'd6);
        run_one(13'd0,    2'b00, "t1_x0");
        run_one(13'd1,    2'b01, "t1_x1");
        run_one(13'd2,    2'b11, "t1_x2");
        run_one(13'd2294, 2'b11, "t1_x2294");
        run_one(13'd2295, 2'b00, "t1_x2295");
        run_one(13'd4590, 2'b11, "t1_x4590");
        end_run("t1");

        // 2: centering around the midpoint and negative lifts
        start_run(13'd4591, 10'd3);
        run_one(13'd2296, 2'b00, "t2_x2296");
        run_one(13'd3000, 2'b11, "t2_x3000");
        run_one(13'd4589, 2'b01, "t2_x4589");
        end_run("t2");

        // 3: backpressure
        out_ready = 1'b0;
        start_run(13'd4591, 10'd2);
        run_one(13'd3000, 2'b11, "t3_first");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("t3_stall", 32'({out_valid, in_ready, out_coef}), 32'b1011);
        end
        out_ready = 1'b1;
        run_one(13'd4589, 2'b01, "t3_second");
        end_run("t3");

        // 4a: even q
        start_run(13'd4590, 10'd3);
        saw_rdy = 1'b0; saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            saw_rdy  = saw_rdy | in_ready;
            saw_done = saw_done | done;
            @(negedge clk);
        end
        check_eq("t4_badq_err", 32'(err), 1);
        check_eq("t4_badq_flags", 32'({saw_done, saw_rdy, busy}), 32'b100);

        // 4b: coefficient out of range
        start_run(13'd4591, 10'd1);
        run_one(13'd4591, 2'b00, "t4_xq");
        end_run("t4_xq");
        check_eq("t4_xq_err", 32'(err), 1);

        // 5: reset during REDUCE
        start_run(13'd4591, 10'd2);
        push(13'd5, "t5_push");
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_outs", 32'({in_ready, out_valid, busy, done, err, out_coef}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        start_run(13'd4591, 10'd1);
        run_one(13'd1, 2'b01, "t5_restart");
        end_run("t5");
        check_eq("t5_err", 32'(err), 0);

        // 6a: empty run
        start_run(13'd4591, 10'd0);
        saw_rdy = 1'b0; saw_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            saw_rdy  = saw_rdy | in_ready;
            saw_done = saw_done | done;
            @(negedge clk);
        end
        check_eq("t6_empty", 32'({saw_done, saw_rdy, err, busy}), 32'b1000);

        // 6b: start while busy is ignored
        start_run(13'd4591, 10'd2);
        push(13'd2, "t6b_push");
        start = 1'b1; q = 13'd4590; n_coeffs = 10'd1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_out(2'b11, "t6b_first", lat);
        run_one(13'd4589, 2'b01, "t6b_second");
        end_run("t6b");
        check_eq("t6b_err", 32'(err), 0);

        // 6c: M=5 build
        @(negedge clk);
        f_start = 1'b1; f_q = 13'd4591; f_n = 10'd2;
        @(negedge clk);
        f_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            f_in_valid = 1'b1; f_in_coef = (k == 0) ? 13'd4590 : 13'd3;
            n = 0;
            while (f_in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
            @(negedge clk);
            f_in_valid = 1'b0;
            while (f_out_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
            check_eq("t6_m5_timeout", 32'(n >= 50), 0);
            check_eq((k == 0) ? "t6_m5_x4590" : "t6_m5_x3", 32'(f_out_coef),
                     (k == 0) ? 32'h0000_000F : 32'h0000_000E);
        end
        @(negedge clk);
        check_eq("t6_m5_done", 32'({f_done, f_err}), 32'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
